// File: rtl/alu_pkg.sv
// Shared constants for the Mini MIPS ALU sequencer: ALUOp codes, opcode/funct values, FSM states.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [1:0] {StIdle, StDecode, StExec, StResp} seq_state_e;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational opcode/funct decode into ALUOp, B-operand source and branch/illegal flags.
module alu_op_decoder
  import alu_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_op_o,
  output logic       use_imm_o,
  output logic       sign_ext_o,
  output logic       is_beq_o,
  output logic       is_bne_o,
  output logic       illegal_o
);

  always_comb begin
    alu_op_o   = ALU_AND;
    use_imm_o  = 1'b0;
    sign_ext_o = 1'b0;
    is_beq_o   = 1'b0;
    is_bne_o   = 1'b0;
    illegal_o  = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADD:  alu_op_o = ALU_ADD;
          FN_SUB:  alu_op_o = ALU_SUB;
          FN_AND:  alu_op_o = ALU_AND;
          FN_OR:   alu_op_o = ALU_OR;
          FN_XOR:  alu_op_o = ALU_XOR;
          FN_NOR:  alu_op_o = ALU_NOR;
          FN_SLT:  alu_op_o = ALU_SLT;
          default: illegal_o = 1'b1;
        endcase
      end
      OP_ADDI: begin
        alu_op_o   = ALU_ADD;
        use_imm_o  = 1'b1;
        sign_ext_o = 1'b1;
      end
      OP_SLTI: begin
        alu_op_o   = ALU_SLT;
        use_imm_o  = 1'b1;
        sign_ext_o = 1'b1;
      end
      OP_ANDI: begin
        alu_op_o  = ALU_AND;
        use_imm_o = 1'b1;
      end
      OP_ORI: begin
        alu_op_o  = ALU_OR;
        use_imm_o = 1'b1;
      end
      OP_XORI: begin
        alu_op_o  = ALU_XOR;
        use_imm_o = 1'b1;
      end
      OP_BEQ: begin
        alu_op_o = ALU_SUB;
        is_beq_o = 1'b1;
      end
      OP_BNE: begin
        alu_op_o = ALU_SUB;
        is_bne_o = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Four-state sequencer: accepts one decoded instruction, drives the external ALU for one
// cycle, and returns the captured result with branch-taken and illegal flags.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ALU_OP_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [5:0]          req_opcode,
  input  logic [5:0]          req_funct,
  input  logic [DATA_W-1:0]   req_rs_val,
  input  logic [DATA_W-1:0]   req_rt_val,
  input  logic [15:0]         req_imm,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [ALU_OP_W-1:0] alu_op,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic                alu_equal,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_result,
  output logic                resp_branch_taken,
  output logic                resp_illegal
);

  seq_state_e state_q, state_d;

  logic [5:0]          opcode_q, opcode_d;
  logic [5:0]          funct_q, funct_d;
  logic [DATA_W-1:0]   rs_q, rs_d;
  logic [DATA_W-1:0]   rt_q, rt_d;
  logic [15:0]         imm_q, imm_d;
  logic [ALU_OP_W-1:0] op_q, op_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic                illegal_q, illegal_d;
  logic                beq_q, beq_d;
  logic                bne_q, bne_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                taken_q, taken_d;

  logic [2:0] dec_op;
  logic       dec_use_imm, dec_sign_ext, dec_beq, dec_bne, dec_illegal;
  logic [DATA_W-1:0] imm_ext;

  alu_op_decoder u_decoder (
    .opcode_i   (opcode_q),
    .funct_i    (funct_q),
    .alu_op_o   (dec_op),
    .use_imm_o  (dec_use_imm),
    .sign_ext_o (dec_sign_ext),
    .is_beq_o   (dec_beq),
    .is_bne_o   (dec_bne),
    .illegal_o  (dec_illegal)
  );

  assign imm_ext = dec_sign_ext ? {{(DATA_W-16){imm_q[15]}}, imm_q} : {{(DATA_W-16){1'b0}}, imm_q};

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    funct_d    = funct_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    imm_d      = imm_q;
    op_d       = op_q;
    b_d        = b_q;
    illegal_d  = illegal_q;
    beq_d      = beq_q;
    bne_d      = bne_q;
    result_d   = result_q;
    taken_d    = taken_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    // ALU inputs are only driven in StExec so it stays quiet otherwise.
    alu_a      = '0;
    alu_b      = '0;
    alu_op     = '0;
    case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          opcode_d = req_opcode;
          funct_d  = req_funct;
          rs_d     = req_rs_val;
          rt_d     = req_rt_val;
          imm_d    = req_imm;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        op_d      = dec_op;
        b_d       = dec_use_imm ? imm_ext : rt_q;
        illegal_d = dec_illegal;
        beq_d     = dec_beq;
        bne_d     = dec_bne;
        if (dec_illegal) begin
          result_d = '0;
          taken_d  = 1'b0;
          state_d  = StResp;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        alu_a    = rs_q;
        alu_b    = b_q;
        alu_op   = op_q;
        result_d = alu_result;
        taken_d  = (beq_q & alu_equal) | (bne_q & ~alu_equal);
        state_d  = StResp;
      end
      StResp: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      opcode_q  <= '0;
      funct_q   <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      imm_q     <= '0;
      op_q      <= '0;
      b_q       <= '0;
      illegal_q <= 1'b0;
      beq_q     <= 1'b0;
      bne_q     <= 1'b0;
      result_q  <= '0;
      taken_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      funct_q   <= funct_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      imm_q     <= imm_d;
      op_q      <= op_d;
      b_q       <= b_d;
      illegal_q <= illegal_d;
      beq_q     <= beq_d;
      bne_q     <= bne_d;
      result_q  <= result_d;
      taken_q   <= taken_d;
    end
  end

  assign resp_result       = result_q;
  assign resp_branch_taken = taken_q;
  assign resp_illegal      = illegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU, directed plan cases and random instructions
// checked against an instruction-level reference model.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_opcode;
  logic [5:0]  req_funct;
  logic [31:0] req_rs_val;
  logic [31:0] req_rt_val;
  logic [15:0] req_imm;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_equal;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic        resp_branch_taken;
  logic        resp_illegal;

  int checks   = 0;
  int failures = 0;

  alu_op_sequencer dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_opcode        (req_opcode),
    .req_funct         (req_funct),
    .req_rs_val        (req_rs_val),
    .req_rt_val        (req_rt_val),
    .req_imm           (req_imm),
    .alu_a             (alu_a),
    .alu_b             (alu_b),
    .alu_op            (alu_op),
    .alu_result        (alu_result),
    .alu_equal         (alu_equal),
    .resp_valid        (resp_valid),
    .resp_ready        (resp_ready),
    .resp_result       (resp_result),
    .resp_branch_taken (resp_branch_taken),
    .resp_illegal      (resp_illegal)
  );

  always #5 clk = ~clk;

  // Behavioural combinational ALU on the far side of the sequencer.
  always_comb begin
    case (alu_op)
      3'b000:  alu_result = alu_a & alu_b;
      3'b001:  alu_result = alu_a + alu_b;
      3'b010:  alu_result = alu_a - alu_b;
      3'b011:  alu_result = alu_a ^ alu_b;
      3'b100:  alu_result = ~(alu_a | alu_b);
      3'b101:  alu_result = alu_a | alu_b;
      3'b110:  alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_result = 32'hDEAD_BEEF;
    endcase
    alu_equal = (alu_a == alu_b);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Instruction-level model: what the instruction means, not how the sequencer computes it.
  task automatic ref_model(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                           input logic [31:0] rt, input logic [15:0] imm,
                           output logic [31:0] res, output logic taken, output logic ill,
                           output logic [2:0] aop, output logic [31:0] b);
    logic [31:0] sx, zx;
    sx    = {{16{imm[15]}}, imm};
    zx    = {16'h0, imm};
    res   = 32'h0;
    taken = 1'b0;
    ill   = 1'b0;
    aop   = 3'b000;
    b     = rt;
    case (op)
      6'h00: begin
        case (fn)
          6'h20: begin aop = 3'b001; res = rs + rt; end
          6'h22: begin aop = 3'b010; res = rs - rt; end
          6'h24: begin aop = 3'b000; res = rs & rt; end
          6'h25: begin aop = 3'b101; res = rs | rt; end
          6'h26: begin aop = 3'b011; res = rs ^ rt; end
          6'h27: begin aop = 3'b100; res = ~(rs | rt); end
          6'h2A: begin aop = 3'b110; res = {31'h0, $signed(rs) < $signed(rt)}; end
          default: ill = 1'b1;
        endcase
      end
      6'h08: begin aop = 3'b001; b = sx; res = rs + sx; end
      6'h0A: begin aop = 3'b110; b = sx; res = {31'h0, $signed(rs) < $signed(sx)}; end
      6'h0C: begin aop = 3'b000; b = zx; res = rs & zx; end
      6'h0D: begin aop = 3'b101; b = zx; res = rs | zx; end
      6'h0E: begin aop = 3'b011; b = zx; res = rs ^ zx; end
      6'h04: begin aop = 3'b010; res = rs - rt; taken = (rs == rt); end
      6'h05: begin aop = 3'b010; res = rs - rt; taken = (rs != rt); end
      default: ill = 1'b1;
    endcase
  endtask

  // One transaction; hold > 0 keeps resp_ready low for that many cycles while spamming req_valid.
  task automatic run_txn(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [15:0] imm, input int hold);
    logic [31:0] e_res, e_b;
    logic        e_t, e_ill;
    logic [2:0]  e_op;
    int          lat;
    ref_model(op, fn, rs, rt, imm, e_res, e_t, e_ill, e_op, e_b);
    @(negedge clk);
    check("idle_ready", {31'h0, req_ready}, 32'd1);
    resp_ready = (hold == 0);
    req_valid  = 1'b1;
    req_opcode = op;
    req_funct  = fn;
    req_rs_val = rs;
    req_rt_val = rt;
    req_imm    = imm;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    check("busy_ready", {31'h0, req_ready}, 32'd0);
    while (!resp_valid && lat < 8) begin
      if (lat == 2) begin
        check("exec_alu_op", {29'h0, alu_op}, {29'h0, e_op});
        check("exec_alu_a", alu_a, rs);
        check("exec_alu_b", alu_b, e_b);
      end
      @(negedge clk);
      lat++;
    end
    check("latency", lat, e_ill ? 32'd2 : 32'd3);
    if (!resp_valid) begin
      resp_ready = 1'b1;
      return;
    end
    check("resp_result", resp_result, e_res);
    check("resp_taken", {31'h0, resp_branch_taken}, {31'h0, e_t});
    check("resp_illegal", {31'h0, resp_illegal}, {31'h0, e_ill});
    for (int i = 0; i < hold; i++) begin
      req_valid  = 1'b1;
      req_opcode = 6'h00;
      req_funct  = 6'h20;
      req_rs_val = $urandom;
      req_rt_val = $urandom;
      @(negedge clk);
      check("hold_valid", {31'h0, resp_valid}, 32'd1);
      check("hold_ready", {31'h0, req_ready}, 32'd0);
      check("hold_result", resp_result, e_res);
      check("hold_flags", {30'h0, resp_branch_taken, resp_illegal}, {30'h0, e_t, e_ill});
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    check("back_idle", {30'h0, resp_valid, req_ready}, 32'd1);
    check("idle_alu", {alu_op != 3'b000, alu_a != 32'h0, alu_b != 32'h0}, 32'd0);
  endtask

  initial begin
    logic [5:0] ops [12];
    logic [5:0] fns [8];
    ops = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h04, 6'h05, 6'h3F, 6'h02};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h21};
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_opcode = '0;
    req_funct  = '0;
    req_rs_val = '0;
    req_rt_val = '0;
    req_imm    = '0;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'h0, req_ready}, 32'd1);
    check("rst_valid", {31'h0, resp_valid}, 32'd0);
    check("rst_result", resp_result, 32'h0);
    check("rst_alu", {alu_op != 3'b000, alu_a != 32'h0, alu_b != 32'h0}, 32'd0);
    reset = 1'b0;

    // Directed plan cases.
    run_txn(6'h00, 6'h20, 32'd5, 32'd7, 16'h0, 0);
    run_txn(6'h0A, 6'h00, 32'hFFFF_FFFE, 32'h0, 16'hFFFF, 0);
    run_txn(6'h0D, 6'h00, 32'h0000_00F0, 32'h0, 16'h8001, 0);
    run_txn(6'h04, 6'h00, 32'd9, 32'd9, 16'h0, 0);
    run_txn(6'h05, 6'h00, 32'd9, 32'd9, 16'h0, 0);
    run_txn(6'h05, 6'h00, 32'd9, 32'd4, 16'h0, 0);
    run_txn(6'h3F, 6'h00, 32'd1, 32'd2, 16'h3, 5);

    // Reset abort during EXEC.
    @(negedge clk);
    req_valid  = 1'b1;
    req_opcode = 6'h00;
    req_funct  = 6'h22;
    req_rs_val = 32'd50;
    req_rt_val = 32'd8;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("pre_abort_exec_op", {29'h0, alu_op}, 32'd2);
    reset = 1'b1;
    #1;
    check("abort_ready", {31'h0, req_ready}, 32'd1);
    check("abort_valid", {31'h0, resp_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_abort_quiet", {30'h0, resp_valid, req_ready}, 32'd1);
    end
    run_txn(6'h00, 6'h20, 32'd1, 32'd1, 16'h0, 0);

    // Randomized instructions.
    for (int n = 0; n < 60; n++) begin
      logic [5:0]  op, fn;
      logic [31:0] rs, rt;
      op = ops[$urandom_range(11, 0)];
      fn = fns[$urandom_range(7, 0)];
      rs = $urandom;
      rt = ($urandom_range(3, 0) == 0) ? rs : $urandom;
      run_txn(op, fn, rs, rt, 16'($urandom), int'($urandom_range(2, 0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
